approx_err_stat: RTL and testbench
==================================

Name: approx_err_stat

Overview:
- Downstream error-statistics stage for the 8x8 approximate multipliers (inexact_* family).
- Consumes each operand pair (a, b) with the approximate 16-bit product the multiplier produced for it.
- Computes the exact product and the error distance ED = |a*b - prod8|.
- Accumulates per-run statistics over a programmed number of samples: sum of ED, maximum ED and count of erroneous samples. Used on-board for FPGA error characterisation of each approximate design.

Parameters:
- CNT_W, 16, width of num_samples and of the sample/error counters.
- SUM_W, 32, width of the ED accumulator; must satisfy SUM_W >= 16 + CNT_W so it never overflows.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run when IDLE or DONE.
- num_samples  input  CNT_W  samples in the run; sampled on accepted start.
- in_valid  input  1  sample on a/b/prod8 is valid.
- in_ready  output  1  block accepts a sample this cycle.
- a  input  8  multiplicand (unsigned).
- b  input  8  multiplier (unsigned).
- prod8  input  16  approximate product for (a, b).
- busy  output  1  high in RUN and DRAIN.
- done  output  1  high in DONE; statistics stable and valid.
- sum_ed  output  SUM_W  sum of ED over the run.
- max_ed  output  16  largest ED in the run.
- err_cnt  output  CNT_W  samples with ED != 0.

Behaviour:
- Reset: clk and rst only, synchronous, active-high. On rst, state = IDLE and all counters and pipeline valids are cleared. Output reset values: in_ready=0, busy=0, done=0, sum_ed=0, max_ed=0, err_cnt=0. Reset asserted mid-run aborts the run; no partial result is kept.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE, start=1:
  - Latch num_samples.
  - Clear sum_ed, max_ed, err_cnt and the accepted counter.
  - If num_samples==0, go to DONE (zero stats). Otherwise go to RUN.
- start in RUN or DRAIN is ignored.
- RUN:
  - in_ready = 1 while accepted < num_samples.
  - Transfer = in_valid & in_ready; increments accepted.
  - When the last sample transfers, go to DRAIN next cycle and drop in_ready.
- DRAIN: wait until the pipeline is empty, then go to DONE.
- DONE: done=1 and outputs hold until the next accepted start, which drops done the following cycle.
- Pipeline (fixed, no stalls; the consumer always accepts):
  - S1 registers a*b (exact, 16-bit) and prod8 with valid.
  - S2 registers ED = |exact - prod8| (16-bit unsigned, both orderings handled) and nz = (ED != 0).
  - Accumulate on the S2 output: sum_ed += ED, max_ed = max(max_ed, ED), err_cnt += nz.
  - The last sample's contribution is visible 3 cycles after its transfer; done rises at the latest on that cycle + 1.
- in_valid with in_ready=0: no effect, sample not counted.
- Statistics outputs change only in RUN/DRAIN, never in DONE.
- No saturation is required; widths are sized to avoid overflow (max 65535 x 65025 < 2^32).

Decomposition:
- Package approx_err_pkg holds:
  - CNT_W/SUM_W defaults;
  - PROD_W=16;
  - state encoding IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
- One natural sub-module: err_dist16, combinational exact 8x8 multiply plus 16-bit absolute difference. The FSM, pipeline registers and accumulators stay in the top level.

Test Plan:
- Basic run: num_samples=3; samples (10,10,100), (15,15,200), (255,255,65025) back-to-back → sum_ed=25, max_ed=25, err_cnt=1, done=1.
- Over-estimate and extreme: num_samples=2; samples (2,3,10) and (255,255,0) → ED 4 and 65025; sum_ed=65029, max_ed=65025, err_cnt=2.
- Zero-length run: start with num_samples=0 → DONE next cycle, all stats 0, in_ready never asserted.
- Back-pressure and over-drive: num_samples=4 with in_valid toggling 1,0,1,1,0,1,1,1 → exactly 4 samples counted; in_ready=0 after the 4th transfer; extra valids ignored.
- Reset and ignored start: rst during RUN after 2 of 5 samples → all outputs 0, IDLE. A new run of 1 sample (3,3,8) → sum_ed=1. A start pulse during that run is ignored.

Source files
------------

// File: rtl/approx_err_pkg.sv
// Shared widths, FSM encoding and the error-distance helper for approx_err_stat.
package approx_err_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned SUM_W_DEF = 32;
    localparam int unsigned OP_W      = 8;
    localparam int unsigned PROD_W    = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Unsigned absolute difference; either operand may be the larger one.
    function automatic logic [PROD_W-1:0] abs_diff16(input logic [PROD_W-1:0] x,
                                                     input logic [PROD_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/approx_err_stat_if.sv
// Sample stream: operand pair plus the approximate product, valid/ready handshake.
interface approx_err_stat_if;
    import approx_err_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [PROD_W-1:0] prod8;

    modport master (output in_valid, output a, output b, output prod8, input in_ready);
    modport slave  (input in_valid, input a, input b, input prod8, output in_ready);

endinterface

// File: rtl/err_dist16.sv
// Exact 8x8 product for stage 1 and |exact - approx| for stage 2 (combinational).
module err_dist16
    import approx_err_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    input  logic [PROD_W-1:0] exact,
    input  logic [PROD_W-1:0] approx,
    output logic [PROD_W-1:0] prod_c,
    output logic [PROD_W-1:0] ed_c,
    output logic              nz_c
);

    assign prod_c = PROD_W'(a) * PROD_W'(b);
    assign ed_c   = abs_diff16(exact, approx);
    assign nz_c   = (ed_c != '0);

endmodule

// File: rtl/approx_err_stat.sv
// Error statistics over a programmed number of approximate-multiplier samples.
module approx_err_stat
    import approx_err_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned SUM_W = SUM_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    approx_err_stat_if.slave   smp,
    output logic               busy,
    output logic               done,
    output logic [SUM_W-1:0]   sum_ed,
    output logic [PROD_W-1:0]  max_ed,
    output logic [CNT_W-1:0]   err_cnt
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  num_lat;
    logic [CNT_W-1:0]  accepted;
    logic              in_ready;
    logic              s1_v;
    logic [PROD_W-1:0] s1_exact;
    logic [PROD_W-1:0] s1_prod;
    logic              s2_v;
    logic [PROD_W-1:0] s2_ed;
    logic              s2_nz;

    logic              xfer_c;
    logic              start_ok_c;
    logic [CNT_W-1:0]  acc_inc_c;
    logic              last_c;
    logic [PROD_W-1:0] prod_c;
    logic [PROD_W-1:0] ed_c;
    logic              nz_c;

    assign smp.in_ready = in_ready;
    assign xfer_c       = smp.in_valid & in_ready;
    assign start_ok_c   = start & ((state == ST_IDLE) | (state == ST_DONE));
    assign acc_inc_c    = accepted + CNT_W'(1);
    assign last_c       = xfer_c & (acc_inc_c == num_lat);

    err_dist16 u_dist (
        .a      (smp.a),
        .b      (smp.b),
        .exact  (s1_exact),
        .approx (s1_prod),
        .prod_c (prod_c),
        .ed_c   (ed_c),
        .nz_c   (nz_c)
    );

    // Next-state logic; DRAIN leaves only once both pipeline stages are empty.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = (num_samples == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_c) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_v && !s2_v) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register with registered status decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_RUN) | (state_nxt == ST_DRAIN);
            done  <= (state_nxt == ST_DONE);
        end
    end

    // Run bookkeeping: sample budget, accepted count and input readiness.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_lat  <= '0;
            accepted <= '0;
            in_ready <= 1'b0;
        end else if (start_ok_c) begin
            num_lat  <= num_samples;
            accepted <= '0;
            in_ready <= (num_samples != '0);
        end else if (xfer_c) begin
            accepted <= acc_inc_c;
            if (last_c) begin
                in_ready <= 1'b0;
            end
        end
    end

    // Two-stage pipeline: exact product, then error distance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v     <= 1'b0;
            s1_exact <= '0;
            s1_prod  <= '0;
            s2_v     <= 1'b0;
            s2_ed    <= '0;
            s2_nz    <= 1'b0;
        end else begin
            s1_v <= xfer_c;
            s2_v <= s1_v;
            if (xfer_c) begin
                s1_exact <= prod_c;
                s1_prod  <= smp.prod8;
            end
            if (s1_v) begin
                s2_ed <= ed_c;
                s2_nz <= nz_c;
            end
        end
    end

    // Statistics accumulators, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
        end else if (start_ok_c) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
        end else if (s2_v) begin
            sum_ed  <= sum_ed + SUM_W'(s2_ed);
            err_cnt <= err_cnt + CNT_W'(s2_nz);
            if (s2_ed > max_ed) begin
                max_ed <= s2_ed;
            end
        end
    end

endmodule

// File: tb/tb_approx_err_stat.sv
// Scoreboard bench for approx_err_stat: per-run expected stats queued at drive time.
module tb_approx_err_stat;

    typedef struct {
        longint sum;
        int     mx;
        int     err;
    } stat_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic        busy;
    logic        done;
    logic [31:0] sum_ed;
    logic [15:0] max_ed;
    logic [15:0] err_cnt;

    int n_chk;
    int n_err;

    int     model_num;
    int     model_acc;
    longint model_sum;
    int     model_max;
    int     model_err;
    stat_t  exp_q[$];

    approx_err_stat_if sif ();

    approx_err_stat dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .smp         (sif.slave),
        .busy        (busy),
        .done        (done),
        .sum_ed      (sum_ed),
        .max_ed      (max_ed),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear(input int n);
        model_num = n;
        model_acc = 0;
        model_sum = 0;
        model_max = 0;
        model_err = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_start(input int n);
        start       = 1'b1;
        num_samples = 16'(n);
        @(negedge clk);
        start = 1'b0;
        model_clear(n);
        if (n == 0) begin
            check("zero_done", longint'(done), 1);
            check("zero_ready", longint'(sif.in_ready), 0);
        end else begin
            check("start_busy", longint'(busy), 1);
            check("start_done_low", longint'(done), 0);
        end
    endtask

    // Drive one cycle of stimulus; the model takes only the first model_num valids.
    task automatic drive(input logic v, input int a, input int b, input int p);
        int exact;
        int ed;
        logic exp_rdy;
        exp_rdy = (model_acc < model_num);
        sif.in_valid = v;
        sif.a        = 8'(a);
        sif.b        = 8'(b);
        sif.prod8    = 16'(p);
        check("in_ready", longint'(sif.in_ready), longint'(exp_rdy));
        if (v && exp_rdy) begin
            model_acc++;
            exact = a * b;
            ed = (exact > p) ? (exact - p) : (p - exact);
            model_sum += longint'(ed);
            if (ed > model_max) model_max = ed;
            if (ed != 0) model_err++;
        end
        @(negedge clk);
    endtask

    task automatic finish_run();
        stat_t e;
        stat_t got;
        int cyc;
        sif.in_valid = 1'b0;
        e.sum = model_sum;
        e.mx  = model_max;
        e.err = model_err;
        exp_q.push_back(e);
        cyc = 0;
        while (!done && cyc < 4) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", longint'(done), 1);
        if (exp_q.size() == 0) begin
            check("queue_nonempty", 0, 1);
        end else begin
            got = exp_q.pop_front();
            check("sum_ed", longint'(sum_ed), got.sum);
            check("max_ed", longint'(max_ed), longint'(got.mx));
            check("err_cnt", longint'(err_cnt), longint'(got.err));
            check("done_busy", longint'(busy), 0);
            check("done_ready", longint'(sif.in_ready), 0);
            repeat (3) @(negedge clk);
            check("hold_sum", longint'(sum_ed), got.sum);
            check("hold_done", longint'(done), 1);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ready"}, longint'(sif.in_ready), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_sum"}, longint'(sum_ed), 0);
        check({tag, "_max"}, longint'(max_ed), 0);
        check({tag, "_err"}, longint'(err_cnt), 0);
    endtask

    initial begin
        logic [7:0] vpat;
        n_chk = 0;
        n_err = 0;
        model_clear(0);
        rst          = 1'b1;
        start        = 1'b0;
        num_samples  = '0;
        sif.in_valid = 1'b0;
        sif.a        = '0;
        sif.b        = '0;
        sif.prod8    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset");

        // Basic run, back-to-back samples.
        do_start(3);
        drive(1'b1, 10, 10, 100);
        drive(1'b1, 15, 15, 200);
        drive(1'b1, 255, 255, 65025);
        finish_run();

        // Over-estimate and extreme error, started from DONE.
        do_start(2);
        drive(1'b1, 2, 3, 10);
        drive(1'b1, 255, 255, 0);
        finish_run();

        // Zero-length run.
        do_start(0);
        finish_run();

        // Gapped valids with extra samples beyond the budget.
        vpat = 8'b1110_1101;
        do_start(4);
        for (int i = 0; i < 8; i++) begin
            drive(vpat[i], i * 31 + 7, i * 13 + 40, (i * 997 + 300) % 65536);
        end
        finish_run();

        // Reset mid-run aborts.
        do_start(5);
        drive(1'b1, 100, 200, 1234);
        drive(1'b1, 50, 60, 3000);
        sif.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("midrst");
        @(negedge clk);
        check_idle_zero("midrst2");

        // Single-sample run with an ignored start during RUN.
        do_start(1);
        start       = 1'b1;
        num_samples = 16'd9;
        drive(1'b1, 3, 3, 8);
        start = 1'b0;
        finish_run();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
